nn_frame_sequencer: RTL and testbench



---
 rtl/nn_frame_sequencer_pkg.sv | 21 ++
 rtl/nn_frame_sequencer_collector.sv | 61 ++++++
 rtl/nn_frame_sequencer.sv | 114 +++++++++++
 tb/tb_nn_frame_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_frame_sequencer_pkg.sv
// Shared constants and types for the speech-NN frame sequencer.
// Defaults describe the production network; benches override via parameters.
package nn_frame_sequencer_pkg;

  localparam int IN_SIZE_1    = 16;
  localparam int NN_LATENCY_1 = 8;
  localparam int CLASS_W_1    = 2;

  typedef logic signed [7:0] feat_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    RESULT  = 2'd2
  } seq_state_t;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESULT  = 2'd2;

endpackage

// File: rtl/nn_frame_sequencer_collector.sv
// Serial-to-parallel feature collector with framing check.
// frame_o already carries the sample being accepted, so the top can latch it on the same edge.
module nn_frame_collector
  import nn_frame_sequencer_pkg::*;
#(
  parameter int IN_SIZE = IN_SIZE_1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  feat_t               feat_data_i,
  input  logic                accept_i,
  input  logic                feat_last_i,
  output logic                frame_done_o,
  output logic                frame_err_o,
  output feat_t [IN_SIZE-1:0] frame_o
);

  localparam int IDX_W = $clog2(IN_SIZE);

  logic [IDX_W-1:0]    idx_q, idx_d;
  feat_t [IN_SIZE-1:0] shadow_q, shadow_d;
  logic                err_q, err_d;
  logic                last_slot;

  always_comb begin
    last_slot    = (idx_q == IDX_W'(IN_SIZE - 1));
    shadow_d     = shadow_q;
    idx_d        = idx_q;
    err_d        = 1'b0;
    frame_done_o = 1'b0;
    if (accept_i) begin
      shadow_d[idx_q] = feat_data_i;
      if (last_slot && feat_last_i) begin
        idx_d        = '0;
        frame_done_o = 1'b1;
      end else if (last_slot || feat_last_i) begin
        // Short or overlong frame: drop it and resynchronise on the next sample.
        idx_d = '0;
        err_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign frame_o     = shadow_d;
  assign frame_err_o = err_q;

endmodule

// File: rtl/nn_frame_sequencer.sv
// Sequencer between the feature stream and the NN top: collect, wait the
// pipeline latency, capture the class and hand it out over valid/ready.
//
// state      | meaning
// COLLECT    | accepting features into the shadow buffer
// WAIT       | nn_vector presented, counting down the NN latency
// RESULT     | res_valid high, holding res_class until res_ready
module nn_frame_sequencer
  import nn_frame_sequencer_pkg::*;
#(
  parameter int IN_SIZE    = IN_SIZE_1,
  parameter int NN_LATENCY = NN_LATENCY_1,
  parameter int CLASS_W    = CLASS_W_1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  feat_t               feat_data_i,
  input  logic                feat_valid_i,
  input  logic                feat_last_i,
  output logic                feat_ready_o,
  output feat_t [IN_SIZE-1:0] nn_vector_o,
  input  logic [CLASS_W-1:0]  nn_class_i,
  output logic [CLASS_W-1:0]  res_class_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic                frame_err_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(NN_LATENCY + 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  feat_t [IN_SIZE-1:0] vec_q, vec_d;
  logic [CLASS_W-1:0]  cls_q, cls_d;
  logic                rv_q, rv_d;

  logic                accept;
  logic                frame_done;
  feat_t [IN_SIZE-1:0] frame;

  assign feat_ready_o = (state_q == ST_COLLECT);
  assign accept       = feat_valid_i & feat_ready_o;

  nn_frame_collector #(
    .IN_SIZE (IN_SIZE)
  ) u_collector (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .feat_data_i  (feat_data_i),
    .accept_i     (accept),
    .feat_last_i  (feat_last_i),
    .frame_done_o (frame_done),
    .frame_err_o  (frame_err_o),
    .frame_o      (frame)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    cls_d   = cls_q;
    rv_d    = rv_q;
    case (state_q)
      ST_COLLECT: begin
        if (frame_done) begin
          vec_d   = frame;
          cnt_d   = CNT_W'(NN_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          cls_d   = nn_class_i;
          rv_d    = 1'b1;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready_i) begin
          rv_d    = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      default: begin
        rv_d    = 1'b0;
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      vec_q   <= '0;
      cls_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      cls_q   <= cls_d;
      rv_q    <= rv_d;
    end
  end

  assign nn_vector_o = vec_q;
  assign res_class_o = cls_q;
  assign res_valid_o = rv_q;
  assign busy_o      = (state_q == ST_WAIT) || (state_q == ST_RESULT);

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Self-checking bench for nn_frame_sequencer with IN_SIZE=4, NN_LATENCY=3.
module tb_nn_frame_sequencer;

  localparam int IN_SIZE = 4;
  localparam int LAT     = 3;

  typedef struct packed {
    logic [1:0]  cls;
    logic [31:0] vec;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] feat_data;
  logic              feat_valid, feat_last, feat_ready;
  logic [3:0][7:0]   nn_vector;
  logic [1:0]        class_stub;
  logic [1:0]        res_class;
  logic              res_valid, res_ready, frame_err, busy;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              err_pulses = 0;
  exp_t            sb[$];
  logic [31:0]     last_vec = '0;

  always #5 clk = ~clk;

  nn_frame_sequencer #(
    .IN_SIZE    (IN_SIZE),
    .NN_LATENCY (LAT),
    .CLASS_W    (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .feat_data_i  (feat_data),
    .feat_valid_i (feat_valid),
    .feat_last_i  (feat_last),
    .feat_ready_o (feat_ready),
    .nn_vector_o  (nn_vector),
    .nn_class_i   (class_stub),
    .res_class_o  (res_class),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic send_feat(input int d, input logic last, input int gap);
    feat_valid = 1'b0;
    feat_last  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    feat_data  = 8'(d);
    feat_last  = last;
    feat_valid = 1'b1;
    n_checks++;
    if (feat_ready !== 1'b1) begin
      n_fail++; $display("FAIL feat_ready_collect: got %b want 1", feat_ready);
    end
    @(posedge clk); #1;
    feat_valid = 1'b0;
    feat_last  = 1'b0;
  endtask

  // Returns one tick after E0 with the expectation queued.
  task automatic send_frame(input int v[4], input int maxgap, input logic [1:0] cls);
    logic [31:0] ev;
    class_stub = cls;
    for (int i = 0; i < IN_SIZE; i++) begin
      ev[i*8 +: 8] = 8'(v[i]);
      send_feat(v[i], (i == IN_SIZE - 1), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    sb.push_back('{cls: cls, vec: ev});
    last_vec = ev;
    n_checks++;
    if (nn_vector !== ev) begin
      n_fail++; $display("FAIL nn_vector_e0: got %h want %h", nn_vector, ev);
    end
    n_checks++;
    if (feat_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ready_busy_e0: got ready=%b busy=%b want 0 1", feat_ready, busy);
    end
  endtask

  task automatic collect_result(input int hold);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (cyc != LAT || res_valid !== 1'b1) begin
      n_fail++; $display("FAIL result_latency: got %0d cycles valid=%b want %0d", cyc, res_valid, LAT);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got 0 entries want 1");
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    if (res_class !== e.cls || nn_vector !== e.vec) begin
      n_fail++; $display("FAIL result_value: got cls=%b vec=%h want cls=%b vec=%h", res_class, nn_vector, e.cls, e.vec);
    end
    for (int i = 0; i < hold; i++) begin
      feat_valid = 1'($urandom_range(0, 1));
      feat_data  = 8'($urandom);
      class_stub = 2'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_class !== e.cls || feat_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL result_hold: got valid=%b cls=%b ready=%b busy=%b want 1 %b 0 1", res_valid, res_class, feat_ready, busy, e.cls);
      end
    end
    feat_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || feat_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL handshake: got valid=%b ready=%b busy=%b want 0 1 0", res_valid, feat_ready, busy);
    end
  endtask

  task automatic check_err_pulse(input string name, input int err0);
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++; $display("FAIL %s_err_high: got %b want 1", name, frame_err);
    end
    @(posedge clk); #1;
    n_checks++;
    if (frame_err !== 1'b0 || err_pulses - err0 != 1) begin
      n_fail++; $display("FAIL %s_err_pulse: got err=%b pulses=%0d want 0 1", name, frame_err, err_pulses - err0);
    end
    n_checks++;
    if (nn_vector !== last_vec || feat_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_discard: got vec=%h ready=%b want %h 1", name, nn_vector, feat_ready, last_vec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; feat_valid = 1'b0; feat_last = 1'b0; feat_data = '0;
    res_ready = 1'b0; class_stub = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (nn_vector !== '0 || res_class !== 2'b00 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got vec=%h cls=%b valid=%b want 0 0 0", nn_vector, res_class, res_valid);
    end
    n_checks++;
    if (feat_ready !== 1'b1 || busy !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got ready=%b busy=%b err=%b want 1 0 0", feat_ready, busy, frame_err);
    end
  endtask

  task automatic test_basic_frame();
    int err0;
    err0 = err_pulses;
    send_frame('{1, -2, 3, -4}, 0, 2'b10);
    collect_result(5);
    n_checks++;
    if (err_pulses != err0) begin
      n_fail++; $display("FAIL basic_no_err: got %0d pulses want 0", err_pulses - err0);
    end
  endtask

  task automatic test_early_last();
    int err0;
    err0 = err_pulses;
    send_feat(5, 1'b0, 0);
    send_feat(6, 1'b1, 0);
    check_err_pulse("early_last", err0);
    send_frame('{10, 20, -30, 40}, 0, 2'b01);
    collect_result(1);
  endtask

  task automatic test_missing_last();
    int err0;
    err0 = err_pulses;
    send_feat(7, 1'b0, 0);
    send_feat(8, 1'b0, 0);
    send_feat(9, 1'b0, 0);
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL missing_last_early_err: got %b want 0", frame_err);
    end
    send_feat(11, 1'b0, 0);
    check_err_pulse("missing_last", err0);
    send_frame('{-128, 127, 0, -1}, 0, 2'b11);
    collect_result(0);
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 3; r++) begin
      send_frame('{1, -2, 3, -4}, 3, 2'(r));
      collect_result(r);
    end
  endtask

  task automatic test_back_to_back();
    send_frame('{4, 3, 2, 1}, 0, 2'b00);
    collect_result(0);
    send_frame('{-5, -6, -7, -8}, 0, 2'b11);
    collect_result(0);
  endtask

  task automatic test_reset_in_wait();
    int rises;
    send_frame('{9, 8, 7, 6}, 0, 2'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    last_vec = '0;
    n_checks++;
    if (nn_vector !== '0 || feat_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_wait: got vec=%h ready=%b busy=%b valid=%b want 0 1 0 0", nn_vector, feat_ready, busy, res_valid);
    end
    rises = 0;
    repeat (6) begin @(posedge clk); #1; if (res_valid !== 1'b0) rises++; end
    n_checks++;
    if (rises != 0) begin
      n_fail++; $display("FAIL reset_wait_no_result: got %0d valid cycles want 0", rises);
    end
    send_frame('{2, 4, 6, 8}, 1, 2'b10);
    collect_result(2);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_early_last();
    test_missing_last();
    test_gaps();
    test_back_to_back();
    test_reset_in_wait();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
